// File: rtl/alu_exec_stage_if.sv
// ---------------------------------------------------------------------------
// alu_exec_stage_if
//   Bundles both handshakes of the execute-stage ALU: the request side
//   (operation + operands from the ALU control decoder) and the response side
//   (head entry of the 2-deep output buffer going to memory/writeback).
//   Ports (all owned by the interface):
//     in_valid/in_ready            request handshake
//     operation[3:0]               op code from the decoder
//     operand_a/operand_b[WIDTH]   rs and rt/immediate operands
//     out_valid/out_ready          response handshake
//     result[WIDTH], zero, overflow, illegal   head entry fields
//     op_count[15:0]               outputs delivered, wraps mod 2^16
//   Modports: master = producer/consumer environment, slave = the stage.
// ---------------------------------------------------------------------------
interface alu_exec_stage_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       operation;
    logic [WIDTH-1:0] operand_a;
    logic [WIDTH-1:0] operand_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             overflow;
    logic             illegal;
    logic [15:0]      op_count;

    modport master (
        output in_valid, operation, operand_a, operand_b, out_ready,
        input  in_ready, out_valid, result, zero, overflow, illegal, op_count
    );

    modport slave (
        input  in_valid, operation, operand_a, operand_b, out_ready,
        output in_ready, out_valid, result, zero, overflow, illegal, op_count
    );
endinterface

// File: rtl/alu_exec_stage.sv
// ---------------------------------------------------------------------------
// alu_exec_stage
//   Execute-stage ALU. Each accepted request is evaluated combinationally and
//   written into a 2-entry FIFO; the FIFO head drives the response side, so a
//   stalled consumer never back-pressures the decoder until both slots fill.
//   Ports:
//     clk    rising-edge clock
//     reset  synchronous, active-high; clears buffer, pointers and op_count
//     bus    alu_exec_stage_if.slave (request/response handshakes, see there)
//   Op codes: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1000 NOP.
//   NOP completes the request handshake but produces no buffer entry; any
//   other unlisted code produces an entry flagged illegal with result 0.
// ---------------------------------------------------------------------------
module alu_exec_stage #(
    parameter int WIDTH = 32
) (
    input  logic              clk,
    input  logic              reset,
    alu_exec_stage_if.slave   bus
);
    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_NOP = 4'b1000;

    // Entry layout: {illegal, overflow, zero, result}
    localparam int EW = WIDTH + 3;

    logic [EW-1:0]    entry_r [0:1];
    logic             headPtr_r;
    logic             tailPtr_r;
    logic [1:0]       count_r;
    logic [15:0]      opCount_r;

    logic [WIDTH-1:0] sum_s;
    logic [WIDTH-1:0] diff_s;
    logic [WIDTH-1:0] aluResult_s;
    logic             aluOvf_s;
    logic             aluIll_s;
    logic             isNop_s;
    logic [EW-1:0]    aluEntry_s;
    logic [EW-1:0]    headEntry_s;
    logic             accept_s;
    logic             push_s;
    logic             pop_s;

    assign sum_s  = bus.operand_a + bus.operand_b;
    assign diff_s = bus.operand_a - bus.operand_b;

    // Operation decode and evaluation for the request currently offered
    always_comb begin
        aluResult_s = {WIDTH{1'b0}};
        aluOvf_s    = 1'b0;
        aluIll_s    = 1'b0;
        isNop_s     = 1'b0;
        case (bus.operation)
            OP_AND: aluResult_s = bus.operand_a & bus.operand_b;
            OP_OR:  aluResult_s = bus.operand_a | bus.operand_b;
            OP_ADD: begin
                aluResult_s = sum_s;
                // Operands agree in sign but the sum does not
                aluOvf_s = (bus.operand_a[WIDTH-1] == bus.operand_b[WIDTH-1]) &&
                           (sum_s[WIDTH-1] != bus.operand_a[WIDTH-1]);
            end
            OP_SUB: begin
                aluResult_s = diff_s;
                // Operands differ in sign and the difference took b's sign
                aluOvf_s = (bus.operand_a[WIDTH-1] != bus.operand_b[WIDTH-1]) &&
                           (diff_s[WIDTH-1] != bus.operand_a[WIDTH-1]);
            end
            OP_SLT: aluResult_s = {{(WIDTH-1){1'b0}},
                                   ($signed(bus.operand_a) < $signed(bus.operand_b))};
            OP_NOP: isNop_s = 1'b1;
            default: aluIll_s = 1'b1;
        endcase
    end

    assign aluEntry_s = {aluIll_s, aluOvf_s, (aluResult_s == {WIDTH{1'b0}}), aluResult_s};

    // in_ready looks only at registered occupancy so it never combinationally
    // follows out_ready; a full buffer refuses input even while draining.
    assign bus.in_ready  = (count_r != 2'd2);
    assign bus.out_valid = (count_r != 2'd0);

    assign accept_s = bus.in_valid & bus.in_ready;
    assign push_s   = accept_s & ~isNop_s;
    assign pop_s    = bus.out_valid & bus.out_ready;

    // Empty buffer presents all-zero fields rather than a stale slot
    always_comb begin
        if (bus.out_valid) begin
            headEntry_s = entry_r[headPtr_r];
        end else begin
            headEntry_s = {EW{1'b0}};
        end
    end

    assign bus.result   = headEntry_s[WIDTH-1:0];
    assign bus.zero     = headEntry_s[WIDTH];
    assign bus.overflow = headEntry_s[WIDTH+1];
    assign bus.illegal  = headEntry_s[WIDTH+2];
    assign bus.op_count = opCount_r;

    // FIFO storage, pointers, occupancy and delivered-output counter
    always_ff @(posedge clk) begin
        if (reset) begin
            entry_r[0] <= {EW{1'b0}};
            entry_r[1] <= {EW{1'b0}};
            headPtr_r  <= 1'b0;
            tailPtr_r  <= 1'b0;
            count_r    <= 2'd0;
            opCount_r  <= 16'd0;
        end else begin
            if (push_s) begin
                entry_r[tailPtr_r] <= aluEntry_s;
                tailPtr_r          <= tailPtr_r + 1'b1;
            end
            if (pop_s) begin
                headPtr_r <= headPtr_r + 1'b1;
                opCount_r <= opCount_r + 16'd1;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + 2'd1;
                2'b01:   count_r <= count_r - 2'd1;
                default: count_r <= count_r;
            endcase
        end
    end
endmodule
